// File: rtl/eprisc_sysx_target.sv
// sysX bus target: decodes master frames into single-cycle local register
// write/read strobes and serialises read data back onto MISO.
module eprisc_sysx_target #(
    parameter logic [1:0] DEVICE_ID = 2'h1
) (
    input  logic        iClock,
    input  logic        iReset,
    input  logic        iBusClock,
    input  logic [0:1]  iBusSelect,
    input  logic [0:7]  iBusMOSI,
    output logic [0:7]  oBusMISO,
    output logic        oBusMISOEnable,
    output logic        oBusInterrupt,
    output logic [0:6]  oRegAddr,
    output logic [0:31] oRegWData,
    output logic        oRegWrite,
    output logic        oRegRead,
    input  logic [0:31] iRegRData,
    input  logic        iDevIrq,
    output logic        oFrameError
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CMD   = 3'd1,
        WDATA = 3'd2,
        RTURN = 3'd3,
        RDATA = 3'd4,
        DONE  = 3'd5
    } state_t;

    logic       busClk_p0, busClk_p1, busClk_p2;
    logic [0:1] sel_p0, sel_p1;
    logic [0:7] mosi_p0, mosi_p1;
    logic [1:0] syncFill;
    logic       armed;

    state_t     state, stateNext;
    logic [1:0] byteCnt, byteCntNext;
    logic       turnSeen, turnSeenNext;
    logic       readPend;
    logic [0:31] shiftReg, shiftRegNext;
    logic [0:6] addrNext;
    logic [0:31] wdataNext;
    logic [0:7] misoNext;
    logic       misoEnReg, misoEnNext;
    logic       writeNext, readNext, errNext;

    logic selected, busRise, busFall, frameActive;

    assign selected    = (sel_p1 == DEVICE_ID);
    assign busRise     = busClk_p1 & ~busClk_p2;
    assign busFall     = ~busClk_p1 & busClk_p2;
    assign frameActive = (state == CMD) || (state == WDATA) ||
                         (state == RTURN) || (state == RDATA);

    // Gating with the live select keeps MISO released the moment select drops.
    assign oBusMISOEnable = misoEnReg & selected;

    // --- stage p0/p1: synchronizers, p2: bus clock edge detect ---
    always_ff @(posedge iClock or posedge iReset) begin
        if (iReset) begin
            busClk_p0     <= 1'b0;
            busClk_p1     <= 1'b0;
            busClk_p2     <= 1'b0;
            sel_p0        <= 2'h0;
            sel_p1        <= 2'h0;
            mosi_p0       <= 8'h00;
            mosi_p1       <= 8'h00;
            syncFill      <= 2'b00;
            armed         <= 1'b0;
            oBusInterrupt <= 1'b0;
        end else begin
            busClk_p0     <= iBusClock;
            busClk_p1     <= busClk_p0;
            busClk_p2     <= busClk_p1;
            sel_p0        <= iBusSelect;
            sel_p1        <= sel_p0;
            mosi_p0       <= iBusMOSI;
            mosi_p1       <= mosi_p0;
            syncFill      <= {syncFill[0], 1'b1};
            // A deselect must be seen after reset before any frame is decoded.
            armed         <= armed | (syncFill[1] & ~selected);
            oBusInterrupt <= iDevIrq;
        end
    end

    // --- frame state register ---
    always_ff @(posedge iClock or posedge iReset) begin
        if (iReset) begin
            state       <= IDLE;
            byteCnt     <= 2'd0;
            turnSeen    <= 1'b0;
            readPend    <= 1'b0;
            shiftReg    <= 32'h0;
            oRegAddr    <= 7'h00;
            oRegWData   <= 32'h0;
            oBusMISO    <= 8'h00;
            misoEnReg   <= 1'b0;
            oRegWrite   <= 1'b0;
            oRegRead    <= 1'b0;
            oFrameError <= 1'b0;
        end else begin
            state       <= stateNext;
            byteCnt     <= byteCntNext;
            turnSeen    <= turnSeenNext;
            readPend    <= oRegRead;
            shiftReg    <= shiftRegNext;
            oRegAddr    <= addrNext;
            oRegWData   <= wdataNext;
            oBusMISO    <= misoNext;
            misoEnReg   <= misoEnNext;
            oRegWrite   <= writeNext;
            oRegRead    <= readNext;
            oFrameError <= errNext;
        end
    end

    always_comb begin
        stateNext    = state;
        byteCntNext  = byteCnt;
        turnSeenNext = turnSeen;
        shiftRegNext = readPend ? iRegRData : shiftReg;
        addrNext     = oRegAddr;
        wdataNext    = oRegWData;
        misoNext     = oBusMISO;
        misoEnNext   = misoEnReg;
        writeNext    = 1'b0;
        readNext     = 1'b0;
        errNext      = 1'b0;

        if (frameActive && !selected) begin
            stateNext  = IDLE;
            misoEnNext = 1'b0;
            misoNext   = 8'h00;
            errNext    = 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (selected && armed) begin
                        stateNext    = CMD;
                        byteCntNext  = 2'd0;
                        turnSeenNext = 1'b0;
                    end
                end
                CMD: begin
                    if (busRise) begin
                        addrNext    = mosi_p1[1:7];
                        byteCntNext = 2'd0;
                        if (mosi_p1[0]) begin
                            stateNext = WDATA;
                        end else begin
                            stateNext    = RTURN;
                            readNext     = 1'b1;
                            turnSeenNext = 1'b0;
                        end
                    end
                end
                WDATA: begin
                    if (busRise) begin
                        wdataNext   = {oRegWData[8:31], mosi_p1};
                        byteCntNext = byteCnt + 2'd1;
                        if (byteCnt == 2'd3) begin
                            writeNext = 1'b1;
                            stateNext = DONE;
                        end
                    end
                end
                RTURN: begin
                    // The falling edge right after the command byte is not the turnaround.
                    if (busRise) begin
                        turnSeenNext = 1'b1;
                    end else if (busFall && turnSeen) begin
                        stateNext    = RDATA;
                        misoEnNext   = 1'b1;
                        misoNext     = shiftReg[0:7];
                        shiftRegNext = {shiftReg[8:31], 8'h00};
                        byteCntNext  = 2'd0;
                    end
                end
                RDATA: begin
                    if (busRise) begin
                        byteCntNext = byteCnt + 2'd1;
                        if (byteCnt == 2'd3) begin
                            stateNext  = DONE;
                            misoEnNext = 1'b0;
                            misoNext   = 8'h00;
                        end
                    end else if (busFall) begin
                        misoNext     = shiftReg[0:7];
                        shiftRegNext = {shiftReg[8:31], 8'h00};
                    end
                end
                DONE: begin
                    if (!selected) begin
                        stateNext = IDLE;
                    end
                end
                default: stateNext = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_eprisc_sysx_target.sv
// Scoreboard bench for eprisc_sysx_target: directed sysX frames, expected
// strobes and MISO bytes queued by stimulus and checked by monitors.
module tb_eprisc_sysx_target;

    localparam int H = 6;
    localparam logic [31:0] RD_VAL = 32'h01234567;
    localparam int K_WR = 1, K_RD = 2, K_ERR = 3, K_MISO = 4;

    logic        iClock, iReset, iBusClock;
    logic [0:1]  iBusSelect;
    logic [0:7]  iBusMOSI;
    logic [0:7]  oBusMISO;
    logic        oBusMISOEnable, oBusInterrupt;
    logic [0:6]  oRegAddr;
    logic [0:31] oRegWData;
    logic        oRegWrite, oRegRead;
    logic [0:31] iRegRData;
    logic        iDevIrq, oFrameError;

    eprisc_sysx_target #(.DEVICE_ID(2'h1)) dut (
        .iClock(iClock), .iReset(iReset), .iBusClock(iBusClock),
        .iBusSelect(iBusSelect), .iBusMOSI(iBusMOSI), .oBusMISO(oBusMISO),
        .oBusMISOEnable(oBusMISOEnable), .oBusInterrupt(oBusInterrupt),
        .oRegAddr(oRegAddr), .oRegWData(oRegWData), .oRegWrite(oRegWrite),
        .oRegRead(oRegRead), .iRegRData(iRegRData), .iDevIrq(iDevIrq),
        .oFrameError(oFrameError)
    );

    typedef struct {
        int          kind;
        logic [31:0] addr;
        logic [31:0] data;
    } ev_t;

    ev_t q[$];
    int  nTests = 0;
    int  nFail  = 0;
    logic rdWasHigh = 1'b0;

    initial begin
        iClock = 1'b0;
        forever #5 iClock = ~iClock;
    end

    // Register file responder: read data valid in the cycle after oRegRead.
    always @(posedge iClock) begin
        #1;
        iRegRData = rdWasHigh ? RD_VAL : 32'hBAD0_BAD0;
        rdWasHigh = oRegRead;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        nTests++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic expectEv(input int k, input logic [31:0] a, input logic [31:0] d);
        ev_t e;
        e.kind = k;
        e.addr = a;
        e.data = d;
        q.push_back(e);
    endtask

    task automatic popCheck(input int k, input logic [31:0] a, input logic [31:0] d);
        ev_t e;
        nTests++;
        if (q.size() == 0) begin
            nFail++;
            $display("FAIL unexpected event: got kind %0d addr %0h data %0h, expected none", k, a, d);
        end else begin
            e = q.pop_front();
            if (e.kind != k || e.addr !== a || e.data !== d) begin
                nFail++;
                $display("FAIL event: got kind %0d addr %0h data %0h, expected kind %0d addr %0h data %0h",
                         k, a, d, e.kind, e.addr, e.data);
            end
        end
    endtask

    always @(negedge iClock) begin
        if (oRegWrite && oRegRead) begin
            nTests++;
            nFail++;
            $display("FAIL strobe overlap: got write=1 read=1, expected at most one");
        end
        if (oRegWrite)   popCheck(K_WR, {25'h0, oRegAddr}, oRegWData);
        if (oRegRead)    popCheck(K_RD, {25'h0, oRegAddr}, 32'h0);
        if (oFrameError) popCheck(K_ERR, 32'h0, 32'h0);
    end

    // The master samples MISO on its rising edge.
    always @(posedge iBusClock) begin
        if (oBusMISOEnable) popCheck(K_MISO, 32'h0, {24'h0, oBusMISO});
    end

    task automatic waitClk(input int n);
        repeat (n) @(posedge iClock);
        #1;
    endtask

    task automatic sendByte(input logic [7:0] b);
        iBusMOSI = b;
        waitClk(H);
        iBusClock = 1'b1;
        waitClk(H);
        iBusClock = 1'b0;
    endtask

    task automatic selectDev(input logic [1:0] code);
        iBusSelect = code;
        waitClk(6);
    endtask

    task automatic deselect();
        iBusSelect = 2'h0;
        waitClk(6);
    endtask

    task automatic writeFrame(input logic [7:0] cmd, input logic [31:0] d);
        sendByte(cmd);
        sendByte(d[31:24]);
        sendByte(d[23:16]);
        sendByte(d[15:8]);
        sendByte(d[7:0]);
    endtask

    task automatic checkOutputsZero(input string tag);
        check({tag, " miso"},   oBusMISO, 0);
        check({tag, " misoEn"}, oBusMISOEnable, 0);
        check({tag, " addr"},   oRegAddr, 0);
        check({tag, " wdata"},  oRegWData, 0);
        check({tag, " write"},  oRegWrite, 0);
        check({tag, " read"},   oRegRead, 0);
        check({tag, " irq"},    oBusInterrupt, 0);
        check({tag, " ferr"},   oFrameError, 0);
    endtask

    initial begin
        iReset = 1'b1; iBusClock = 1'b0; iBusSelect = 2'h0; iBusMOSI = 8'h00;
        iDevIrq = 1'b1; iRegRData = 32'h0;
        waitClk(3);
        checkOutputsZero("reset");
        iDevIrq = 1'b0;
        iReset = 1'b0;
        waitClk(4);

        // Plain write frame
        selectDev(2'h1);
        expectEv(K_WR, 32'h05, 32'hDEADBEEF);
        writeFrame(8'h85, 32'hDEADBEEF);
        waitClk(4);
        deselect();
        check("write frame queue", q.size(), 0);

        // Read frame
        selectDev(2'h1);
        expectEv(K_RD, 32'h12, 32'h0);
        expectEv(K_MISO, 32'h0, 32'h01);
        expectEv(K_MISO, 32'h0, 32'h23);
        expectEv(K_MISO, 32'h0, 32'h45);
        expectEv(K_MISO, 32'h0, 32'h67);
        sendByte(8'h12);
        sendByte(8'h00);
        for (int i = 0; i < 4; i++) sendByte(8'h00);
        waitClk(4);
        check("read enable drop", oBusMISOEnable, 0);
        deselect();
        check("read frame queue", q.size(), 0);

        // Abort after two data bytes, then a clean frame
        selectDev(2'h1);
        sendByte(8'h85);
        sendByte(8'hDE);
        sendByte(8'hAD);
        expectEv(K_ERR, 32'h0, 32'h0);
        deselect();
        check("abort queue", q.size(), 0);
        selectDev(2'h1);
        expectEv(K_WR, 32'h03, 32'h11223344);
        writeFrame(8'h83, 32'h11223344);
        waitClk(4);
        deselect();
        check("post-abort write queue", q.size(), 0);

        // Another device's select code
        selectDev(2'h2);
        writeFrame(8'h85, 32'hDEADBEEF);
        check("other dev misoEn after write", oBusMISOEnable, 0);
        sendByte(8'h12);
        sendByte(8'h00);
        sendByte(8'h00);
        check("other dev misoEn in read", oBusMISOEnable, 0);
        deselect();
        check("other dev queue", q.size(), 0);

        // Reset during RDATA byte 2
        selectDev(2'h1);
        expectEv(K_RD, 32'h12, 32'h0);
        expectEv(K_MISO, 32'h0, 32'h01);
        expectEv(K_MISO, 32'h0, 32'h23);
        sendByte(8'h12);
        sendByte(8'h00);
        sendByte(8'h00);
        sendByte(8'h00);
        waitClk(4);
        check("rdata byte2 enable", oBusMISOEnable, 1);
        check("rdata byte2 value", oBusMISO, 8'h45);
        iReset = 1'b1;
        #1;
        checkOutputsZero("mid-frame reset");
        waitClk(2);
        iReset = 1'b0;
        waitClk(4);
        writeFrame(8'h85, 32'hDEADBEEF);
        waitClk(4);
        check("held select misoEn", oBusMISOEnable, 0);
        check("held select queue", q.size(), 0);
        deselect();
        selectDev(2'h1);
        expectEv(K_WR, 32'h05, 32'hDEADBEEF);
        writeFrame(8'h85, 32'hDEADBEEF);
        waitClk(4);
        deselect();
        check("after reset write queue", q.size(), 0);

        // Interrupt mirror
        iDevIrq = 1'b1;
        #1;
        check("irq rise latency", oBusInterrupt, 0);
        waitClk(1);
        check("irq rise", oBusInterrupt, 1);
        iDevIrq = 1'b0;
        #1;
        check("irq fall latency", oBusInterrupt, 1);
        waitClk(1);
        check("irq fall", oBusInterrupt, 0);

        // Extra bus clocks in DONE
        selectDev(2'h1);
        expectEv(K_WR, 32'h7F, 32'hCAFEF00D);
        writeFrame(8'hFF, 32'hCAFEF00D);
        for (int i = 0; i < 6; i++) sendByte(8'h81);
        waitClk(4);
        deselect();
        check("done extra clocks queue", q.size(), 0);

        waitClk(10);
        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
